pwm_fade_ctrl: RTL

PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

---
 rtl/pwm_fade_pkg.sv | 14 +
 rtl/pwm_fade_timer.sv | 29 ++
 rtl/pwm_fade_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/pwm_fade_pkg.sv
// rtl/pwm_fade_pkg.sv - shared state encoding and default width for the PWM fade controller
package pwm_fade_pkg;

    localparam int PWM_FADE_BW = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HIGH = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LOW  = 3'd4
    } fade_state_t;

endpackage

// File: rtl/pwm_fade_timer.sv
// rtl/pwm_fade_timer.sv - PWM period counter with end-of-period tick
module pwm_fade_timer
    import pwm_fade_pkg::*;
#(
    parameter int BW = PWM_FADE_BW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          clear,
    input  logic [BW-1:0] period,
    output logic [BW-1:0] pcnt,
    output logic          periodTick
);

    // Tick marks the last cycle of each period; suppressed while held clear.
    assign periodTick = !clear && (pcnt == period);

    // Count 0..period and wrap; clear pins the counter at zero.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear) begin
            pcnt <= '0;
        end else if (pcnt == period) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_fade_ctrl.sv
// rtl/pwm_fade_ctrl.sv - breathing PWM fade FSM; optional gamma map via PWM_FADE_GAMMA_EN
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int BW = PWM_FADE_BW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic [BW-1:0] periodCnt_i,
    input  logic [BW-1:0] step_i,
    input  logic [BW-1:0] ticksPerStep_i,
    input  logic [BW-1:0] holdPeriods_i,
    output logic [BW-1:0] onCnt_o,
    output logic          pwm_o,
    output logic [2:0]    state_o,
    output logic          cycleDone_o
);

    localparam logic [BW-1:0] LEVEL_MAX = '1;

    fade_state_t   state_q, state_d;
    logic [BW-1:0] period_q, step_q, tps_q, hold_q;
    logic [BW-1:0] level_q, level_d;
    logic [BW-1:0] div_q, div_d;
    logic [BW-1:0] hcnt_q, hcnt_d;
    logic          cycle_done_d;
    logic          start;
    logic [BW-1:0] pcnt;
    logic          period_tick;
    logic          timer_clear;
    logic          step_evt;
    logic [BW-1:0] step_eff;
    logic [BW:0]   up_sum;
    logic          up_sat, down_sat;
    logic [BW-1:0] level_up, level_down;

    // Brightness-to-duty mapping; the squaring path only exists in gamma builds.
    function automatic logic [BW-1:0] map_level(input logic [BW-1:0] lvl);
`ifdef PWM_FADE_GAMMA_EN
        logic [2*BW-1:0] sq;
        sq = {{BW{1'b0}}, lvl} * {{BW{1'b0}}, lvl};
        if (lvl == LEVEL_MAX) begin
            return LEVEL_MAX;
        end
        return sq[2*BW-1:BW];
`else
        return lvl;
`endif
    endfunction

    // Timer restarts from zero whenever the sequence is idle or being aborted.
    assign timer_clear = (state_q == ST_IDLE) || !enable_i;

    pwm_fade_timer #(.BW(BW)) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear      (timer_clear),
        .period     (period_q),
        .pcnt       (pcnt),
        .periodTick (period_tick)
    );

    assign step_eff   = (step_q == '0) ? BW'(1) : step_q;
    assign up_sum     = {1'b0, level_q} + {1'b0, step_eff};
    assign up_sat     = up_sum >= {1'b0, LEVEL_MAX};
    assign level_up   = up_sat ? LEVEL_MAX : up_sum[BW-1:0];
    assign down_sat   = step_eff >= level_q;
    assign level_down = down_sat ? '0 : level_q - step_eff;
    assign step_evt   = period_tick && (div_q == tps_q);

    assign pwm_o   = pcnt < onCnt_o;
    assign state_o = state_q;

    // Next-state, level, step divider and hold counter.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        div_d        = div_q;
        hcnt_d       = hcnt_q;
        cycle_done_d = 1'b0;
        start        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                level_d = '0;
                div_d   = '0;
                hcnt_d  = '0;
                if (enable_i) begin
                    state_d = ST_RAMP_UP;
                    start   = 1'b1;
                end
            end
            ST_RAMP_UP: begin
                hcnt_d = '0;
                if (period_tick) begin
                    div_d = step_evt ? '0 : div_q + 1'b1;
                end
                if (step_evt) begin
                    level_d = level_up;
                    if (up_sat) begin
                        state_d = ST_HOLD_HIGH;
                    end
                end
            end
            ST_HOLD_HIGH, ST_HOLD_LOW: begin
                div_d = '0;
                if (period_tick) begin
                    if (hcnt_q == hold_q) begin
                        hcnt_d = '0;
                        if (state_q == ST_HOLD_HIGH) begin
                            state_d = ST_RAMP_DOWN;
                        end else begin
                            state_d      = ST_RAMP_UP;
                            cycle_done_d = 1'b1;
                        end
                    end else begin
                        hcnt_d = hcnt_q + 1'b1;
                    end
                end
            end
            ST_RAMP_DOWN: begin
                hcnt_d = '0;
                if (period_tick) begin
                    div_d = step_evt ? '0 : div_q + 1'b1;
                end
                if (step_evt) begin
                    level_d = level_down;
                    if (down_sat) begin
                        state_d = ST_HOLD_LOW;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                level_d = '0;
                div_d   = '0;
                hcnt_d  = '0;
            end
        endcase
        if (state_q != ST_IDLE && !enable_i) begin
            state_d      = ST_IDLE;
            level_d      = '0;
            div_d        = '0;
            hcnt_d       = '0;
            cycle_done_d = 1'b0;
        end
    end

    // State and counters register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            level_q     <= '0;
            div_q       <= '0;
            hcnt_q      <= '0;
            cycleDone_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            level_q     <= level_d;
            div_q       <= div_d;
            hcnt_q      <= hcnt_d;
            cycleDone_o <= cycle_done_d;
        end
    end

    // Configuration is captured only when leaving IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q <= '0;
            step_q   <= '0;
            tps_q    <= '0;
            hold_q   <= '0;
        end else if (start) begin
            period_q <= periodCnt_i;
            step_q   <= step_i;
            tps_q    <= ticksPerStep_i;
            hold_q   <= holdPeriods_i;
        end
    end

    // Duty compare value changes only at period end so each PWM period is whole.
    always_ff @(posedge clk_i) begin
        if (rst_i || state_d == ST_IDLE) begin
            onCnt_o <= '0;
        end else if (period_tick) begin
            onCnt_o <= map_level(level_d);
        end
    end

endmodule
